// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter.
package rr_arb_pkg;
    localparam int NUM_REQ = 4;
    localparam int HOLD_W  = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;
endpackage

// File: rtl/rr_pick_4.sv
// Combinational round-robin picker: first set request bit at or after ptr, wrapping mod 4.
module rr_pick_4
    import rr_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [1:0]         winner_id,
    output logic               any
);
    logic       found;
    logic [1:0] idx;

    assign any = |req;

    always_comb begin
        found     = 1'b0;
        winner_id = 2'd0;
        idx       = 2'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                found     = 1'b1;
                winner_id = idx;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
            assign winner[gi] = any && (winner_id == 2'(gi));
        end
    endgenerate
endmodule

// File: rtl/rr_arb_4.sv
// Four-requester round-robin arbiter with done-based release and a grant-hold timeout.
module rr_arb_4
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   req,
    input  logic         done,
    output logic [3:0]   gnt,
    output logic [1:0]   gnt_id,
    output logic         gnt_v,
    output logic         timeout
);
    arb_state_t        state_reg, state_next;
    logic [1:0]        ptr_reg, ptr_next;
    logic [HOLD_W-1:0] hold_reg, hold_next;
    logic [3:0]        gnt_reg, gnt_next;
    logic [1:0]        gnt_id_reg, gnt_id_next;
    logic              gnt_v_reg, gnt_v_next;
    logic              timeout_reg, timeout_next;

    logic [3:0] pick_onehot;
    logic [1:0] pick_id;
    logic       pick_any;

    rr_pick_4 u_pick (
        .req       (req),
        .ptr       (ptr_reg),
        .winner    (pick_onehot),
        .winner_id (pick_id),
        .any       (pick_any)
    );

    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        hold_next    = hold_reg;
        gnt_next     = gnt_reg;
        gnt_id_next  = gnt_id_reg;
        gnt_v_next   = gnt_v_reg;
        timeout_next = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (pick_any) begin
                    state_next  = GRANT;
                    gnt_next    = pick_onehot;
                    gnt_id_next = pick_id;
                    gnt_v_next  = 1'b1;
                    hold_next   = '0;
                end
            end
            GRANT: begin
                // done wins over a coinciding timeout, so that case is a normal release
                if (done || hold_reg == HOLD_W'(MAX_HOLD - 1)) begin
                    state_next   = IDLE;
                    ptr_next     = gnt_id_reg + 2'd1;
                    gnt_next     = '0;
                    gnt_id_next  = '0;
                    gnt_v_next   = 1'b0;
                    timeout_next = !done;
                end else begin
                    hold_next = hold_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            hold_reg    <= '0;
            gnt_reg     <= '0;
            gnt_id_reg  <= '0;
            gnt_v_reg   <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            hold_reg    <= hold_next;
            gnt_reg     <= gnt_next;
            gnt_id_reg  <= gnt_id_next;
            gnt_v_reg   <= gnt_v_next;
            timeout_reg <= timeout_next;
        end
    end

    assign gnt     = gnt_reg;
    assign gnt_id  = gnt_id_reg;
    assign gnt_v   = gnt_v_reg;
    assign timeout = timeout_reg;
endmodule

// File: tb/tb_rr_arb_4.sv
// Self-checking bench for rr_arb_4: directed scenarios plus random traffic against a behavioural model.
module tb_rr_arb_4;
    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       done = 1'b0;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_v;
    logic       timeout;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: who owns the grant, for how many cycles, and where the search starts.
    bit m_busy  = 1'b0;
    int m_owner = 0;
    int m_ptr   = 0;
    int m_held  = 0;
    bit m_to    = 1'b0;

    rr_arb_4 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_v   (gnt_v),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int first_from(input int start, input logic [3:0] r);
        for (int k = 0; k < 4; k++) begin
            if (r[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_edge(input logic r_rst, input logic [3:0] r_req, input logic r_done);
        if (r_rst) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_held = 0; m_to = 0;
        end else if (!m_busy) begin
            m_to = 0;
            if (r_req != 0) begin
                m_busy  = 1;
                m_owner = first_from(m_ptr, r_req);
                m_held  = 1;
            end
        end else begin
            m_to = 0;
            if (r_done || m_held == MAX_HOLD) begin
                m_busy = 0;
                m_ptr  = (m_owner + 1) % 4;
                m_to   = !r_done;
            end else begin
                m_held++;
            end
        end
    endtask

    // Apply one cycle of inputs, clock it, then compare all outputs with the model.
    task automatic step(input logic r_rst, input logic [3:0] r_req, input logic r_done);
        logic [3:0] exp_gnt;
        rst = r_rst; req = r_req; done = r_done;
        @(posedge clk);
        model_edge(r_rst, r_req, r_done);
        #1;
        exp_gnt = m_busy ? 4'(1 << m_owner) : 4'b0000;
        chk("gnt", 8'(gnt), 8'(exp_gnt));
        chk("gnt_id", 8'(gnt_id), m_busy ? 8'(m_owner) : 8'd0);
        chk("gnt_v", 8'(gnt_v), 8'(m_busy));
        chk("timeout", 8'(timeout), 8'(m_to));
        $display("t=%0t rst=%b req=%b done=%b -> gnt=%b id=%0d v=%b to=%b",
                 $time, r_rst, r_req, r_done, gnt, gnt_id, gnt_v, timeout);
    endtask

    initial begin
        @(negedge clk);
        step(1, 4'b0000, 0);
        chk("reset_gnt", 8'(gnt), 8'h0);

        // Alternate requesters 1 and 3
        step(0, 4'b1010, 0);
        chk("s28_first", 8'(gnt), 8'h02);
        step(0, 4'b1010, 1);
        chk("s28_gap", 8'(gnt_v), 8'h0);
        step(0, 4'b1010, 0);
        chk("s28_second", 8'(gnt_id), 8'd3);
        step(0, 4'b1010, 1);

        // Rotation through all four
        step(0, 4'b1010, 0);
        chk("s29_first", 8'(gnt), 8'h02);
        step(0, 4'b1111, 1);
        step(0, 4'b1111, 0);
        chk("s29_id2", 8'(gnt_id), 8'd2);
        step(0, 4'b1111, 1);
        step(0, 4'b1111, 0);
        chk("s29_id3", 8'(gnt_id), 8'd3);
        step(0, 4'b1111, 1);
        step(0, 4'b1111, 0);
        chk("s29_id0", 8'(gnt), 8'h01);
        step(0, 4'b0000, 1);

        // Forced release after MAX_HOLD cycles
        step(0, 4'b0001, 0);
        for (int i = 0; i < MAX_HOLD - 1; i++) begin
            step(0, 4'b0001, 0);
            chk("s30_hold", 8'(gnt), 8'h01);
        end
        step(0, 4'b0001, 0);
        chk("s30_release", 8'(gnt), 8'h0);
        chk("s30_timeout", 8'(timeout), 8'h1);
        step(0, 4'b0011, 0);
        chk("s30_next_id", 8'(gnt_id), 8'd1);
        chk("s30_to_clear", 8'(timeout), 8'h0);
        step(0, 4'b0000, 1);

        // done on the last allowed cycle is a normal release
        step(0, 4'b0001, 0);
        for (int i = 0; i < MAX_HOLD - 1; i++) step(0, 4'b0001, 0);
        step(0, 4'b0001, 1);
        chk("s31_release", 8'(gnt_v), 8'h0);
        chk("s31_no_timeout", 8'(timeout), 8'h0);

        // Reset mid-grant, with done in the same cycle
        step(0, 4'b0100, 0);
        chk("s32_granted", 8'(gnt), 8'h04);
        step(1, 4'b0100, 1);
        chk("s32_reset", 8'(gnt), 8'h0);
        step(0, 4'b1100, 0);
        chk("s32_ptr0", 8'(gnt_id), 8'd2);
        step(0, 4'b0000, 1);

        // Owner drops req mid-grant; done in IDLE is ignored
        step(0, 4'b0010, 0);
        step(0, 4'b0000, 0);
        chk("s33_held", 8'(gnt), 8'h02);
        step(0, 4'b0000, 1);
        step(0, 4'b0000, 1);
        chk("s33_idle_done", 8'(gnt_v), 8'h0);
        step(0, 4'b0000, 0);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rr_arb_4.md
RR_ARB_4 -- requirements
Module: rr_arb_4

Interface
REQ-001 SHALL have parameter: MAX_HOLD, 15, grant-hold cycle limit before forced release (legal 2..255).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: req  input  4  request lines, bit n = requester n.
REQ-005 SHALL have port: done  input  1  single-cycle pulse from granted requester releasing the grant.
REQ-006 SHALL have port: gnt  output  4  registered one-hot grant, or 4'b0000.
REQ-007 SHALL have port: gnt_id  output  2  registered binary index of the granted requester.
REQ-008 SHALL have port: gnt_v  output  1  registered grant valid; 1 iff gnt != 0.
REQ-009 SHALL have port: timeout  output  1  registered one-cycle pulse on forced release.

Function
REQ-010 SHALL implement two states: IDLE and GRANT.
REQ-011 SHALL arbitrate in IDLE when req != 0, with search order ptr, ptr+1, ptr+2, ptr+3 (mod 4); the first set bit wins.
REQ-012 SHALL, one edge after an IDLE cycle with req != 0: set gnt to the winner's one-hot value, gnt_id to its index, gnt_v=1, hold_cnt=0, and state=GRANT.
REQ-013 SHALL hold gnt, gnt_id and gnt_v stable in GRANT regardless of req changes, including the granted requester dropping its req.
REQ-014 SHALL increment hold_cnt (8-bit) once per GRANT cycle that has no release.
REQ-015 SHALL release on done=1 in GRANT: next edge gnt=0, gnt_v=0, gnt_id=0, state=IDLE, ptr=gnt_id+1 (mod 4).
REQ-016 SHALL force release when in GRANT with done=0 and hold_cnt==MAX_HOLD-1: same updates as REQ-015, plus timeout=1 for exactly one cycle.
REQ-017 SHALL treat done and the timeout condition in the same cycle as a normal release, with timeout=0.
REQ-018 SHALL ignore done in IDLE.
REQ-019 SHALL spend at least one IDLE cycle between consecutive grants, so gnt_v drops for at least one cycle.
REQ-020 SHALL stay in IDLE with all outputs 0 and ptr unchanged while req==0.
REQ-021 SHALL never assert more than one gnt bit; gnt_id SHALL always encode gnt when gnt_v=1.
REQ-022 SHALL keep gnt high for at most MAX_HOLD consecutive cycles.

Reset
REQ-023 SHALL, on a rising edge with rst=1, set state=IDLE, ptr=0, hold_cnt=0, gnt=0, gnt_id=0, gnt_v=0, timeout=0.
REQ-024 SHALL give rst priority over all other inputs, including mid-grant and same-cycle done; the next grant after reset SHALL use ptr=0.

Structure
REQ-025 SHALL place the state enum (IDLE, GRANT), NUM_REQ=4, and the hold_cnt width constant in shared package rr_arb_pkg.
REQ-026 SHALL use one combinational sub-module, rr_pick_4 (inputs req[3:0] and ptr[1:0]; outputs winner one-hot[3:0], winner index[1:0], any).
REQ-027 SHALL register all outputs with no combinational path from inputs to outputs.

Verification
REQ-028 SHALL cover: reset, then req=4'b1010 held -> gnt=4'b0010, gnt_id=1, gnt_v=1 one edge later; after done, gnt=0 for one cycle, then gnt=4'b1000, gnt_id=3.
REQ-029 SHALL cover: continuing REQ-028 (ptr=0 after the id-3 release), req=4'b1010 -> gnt=4'b0010; with req=4'b1111 held and done given every grant, the grant sequence is 1,2,3,0.
REQ-030 SHALL cover: MAX_HOLD=4, req=4'b0001, no done -> gnt=4'b0001 for exactly 4 cycles, then gnt=0 with timeout=1 for one cycle; next req=4'b0011 grants id 1.
REQ-031 SHALL cover: MAX_HOLD=4, done asserted on the 4th grant cycle -> release with timeout=0.
REQ-032 SHALL cover: rst=1 while gnt=4'b0100 -> next edge all outputs 0; req=4'b1100 then grants id 2 (ptr=0).
REQ-033 SHALL cover: the granted requester drops req mid-grant -> gnt held until done; done pulsed in IDLE -> no state or output change.
